// File: rtl/wisc_pipe_pkg.sv
// wisc_pipe_pkg: shared state encoding, default delays and counter sizing for the WISC pipeline control
package wisc_pipe_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_e;
    localparam int DEF_DEPTH    = 5;
    localparam int DEF_NREG     = 16;
    localparam int DEF_LD_DLY   = 1;
    localparam int DEF_ALU_DLY  = 0;
    localparam int DEF_BR_EXTRA = 1;
    // Width that holds the largest scoreboard load value, never below one bit.
    function automatic int cnt_w(input int ld, input int alu, input int br);
        int m;
        int w;
        m = ld > alu ? ld : alu;
        w = $clog2(m + br + 1);
        return w < 1 ? 1 : w;
    endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// hz_scoreboard: per-register and flag delay counters with the ID-stage hazard compare
// Ports: clk, rst (async active-low); adv_i advances counts; issue_i commits the ID instruction;
// rs/rt/rd, use/write/load/branch/flag qualifiers from decode; hazard_o flags a blocking source.
module hz_scoreboard
    import wisc_pipe_pkg::*;
#(
    parameter int NREG     = DEF_NREG,
    parameter int RAW      = $clog2(NREG),
    parameter int LD_DLY   = DEF_LD_DLY,
    parameter int ALU_DLY  = DEF_ALU_DLY,
    parameter int BR_EXTRA = DEF_BR_EXTRA
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           adv_i,
    input  logic           issue_i,
    input  logic [RAW-1:0] rs_i,
    input  logic [RAW-1:0] rt_i,
    input  logic [RAW-1:0] rd_i,
    input  logic           rs_used_i,
    input  logic           rt_used_i,
    input  logic           wr_i,
    input  logic           load_i,
    input  logic           br_i,
    input  logic           sets_flags_i,
    input  logic           uses_flags_i,
    output logic           hazard_o
);
    localparam int CW = cnt_w(LD_DLY, ALU_DLY, BR_EXTRA);
    localparam logic [CW-1:0] LD_V  = CW'(LD_DLY + BR_EXTRA);
    localparam logic [CW-1:0] ALU_V = CW'(ALU_DLY + BR_EXTRA);
    localparam logic [CW-1:0] BRX   = CW'(BR_EXTRA);

    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [CW-1:0] rs_c, rt_c;
    logic          rs_h, rt_h;

    // A fresh issue overrides the same register's decrement in this cycle.
    always_comb begin
        for (int r = 0; r < NREG; r++)
            cnt_d[r] = (adv_i && cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : cnt_q[r];
        fcnt_d = (adv_i && fcnt_q != '0) ? fcnt_q - 1'b1 : fcnt_q;
        if (issue_i && wr_i && rd_i != '0)
            cnt_d[rd_i] = load_i ? LD_V : ALU_V;
        if (issue_i && sets_flags_i)
            fcnt_d = ALU_V;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '{default: '0};
            fcnt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            fcnt_q <= fcnt_d;
        end
    end

    // ID-stage readers need the value BR_EXTRA cycles earlier than EX readers.
    assign rs_c     = cnt_q[rs_i];
    assign rt_c     = cnt_q[rt_i];
    assign rs_h     = rs_used_i && rs_i != '0 && (br_i ? rs_c != '0 : rs_c > BRX);
    assign rt_h     = rt_used_i && rt_i != '0 && (br_i ? rt_c != '0 : rt_c > BRX);
    assign hazard_o = rs_h || rt_h || (uses_flags_i && fcnt_q != '0);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/enable control and halt drain for the WISC in-order pipeline
// Ports: clk, rst (async active-low); id_* decode of the ID-stage instruction; mem_stall freezes
// everything; pc_en and pipe-register enables; if_id_flush/id_ex_flush bubbles; stall, hlt, state.
module pipe_hazard_ctrl
    import wisc_pipe_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NREG     = DEF_NREG,
    parameter int RAW      = $clog2(NREG),
    parameter int LD_DLY   = DEF_LD_DLY,
    parameter int ALU_DLY  = DEF_ALU_DLY,
    parameter int BR_EXTRA = DEF_BR_EXTRA
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           id_valid,
    input  logic [RAW-1:0] id_rs,
    input  logic [RAW-1:0] id_rt,
    input  logic [RAW-1:0] id_rd,
    input  logic           id_rs_used,
    input  logic           id_rt_used,
    input  logic           id_wr,
    input  logic           id_is_load,
    input  logic           id_is_br,
    input  logic           id_br_taken,
    input  logic           id_sets_flags,
    input  logic           id_uses_flags,
    input  logic           id_is_halt,
    input  logic           mem_stall,
    output logic           pc_en,
    output logic           if_id_en,
    output logic           id_ex_en,
    output logic           ex_mem_en,
    output logic           mem_wb_en,
    output logic           if_id_flush,
    output logic           id_ex_flush,
    output logic           stall,
    output logic           hlt,
    output logic [1:0]     state
);
    localparam int DW = $clog2(DEPTH);

    state_e        state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          haz, issue;

    hz_scoreboard #(
        .NREG(NREG), .RAW(RAW), .LD_DLY(LD_DLY), .ALU_DLY(ALU_DLY), .BR_EXTRA(BR_EXTRA)
    ) u_sb (
        .clk(clk), .rst(rst), .adv_i(!mem_stall), .issue_i(issue),
        .rs_i(id_rs), .rt_i(id_rt), .rd_i(id_rd),
        .rs_used_i(id_rs_used), .rt_used_i(id_rt_used), .wr_i(id_wr), .load_i(id_is_load),
        .br_i(id_is_br), .sets_flags_i(id_sets_flags), .uses_flags_i(id_uses_flags),
        .hazard_o(haz)
    );

    assign stall = id_valid && state_q == RUN && haz && !mem_stall;
    assign issue = id_valid && state_q == RUN && !haz && !mem_stall;
    assign hlt   = state_q == HALTED || (state_q == DRAIN && drain_q == '0);
    assign state = state_q;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        if (issue && id_is_halt) begin
            state_d = DRAIN;
            drain_d = DW'(DEPTH - 3);
        end else if (state_q == DRAIN && !mem_stall) begin
            state_d = drain_q == '0 ? HALTED : DRAIN;
            drain_d = drain_q == '0 ? drain_q : drain_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // The halting cycle already blocks fetch so nothing younger than HLT enters ID.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (mem_stall || state_q == HALTED) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (state_q == DRAIN || (issue && id_is_halt)) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
        end else if (stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (issue && id_br_taken) begin
            if_id_flush = 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus randomized decode checked against a ready-time model
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_rs_used, id_rt_used, id_wr, id_is_load, id_is_br, id_br_taken;
    logic id_sets_flags, id_uses_flags, id_is_halt, mem_stall;
    logic [3:0] id_rs, id_rt, id_rd;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, stall, hlt;
    logic [1:0] state;
    logic [8:0] outs;
    int checks = 0;
    int errors = 0;

    localparam logic [8:0] OK  = 9'b111110000;
    localparam logic [8:0] STL = 9'b001110110;
    localparam logic [8:0] BRF = 9'b111111000;
    localparam logic [8:0] DRN = 9'b011111000;
    localparam logic [8:0] DRH = 9'b011111001;
    localparam logic [8:0] HLD = 9'b000000001;

    always #5 clk = ~clk;

    assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, stall, hlt};

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr(id_wr), .id_is_load(id_is_load),
        .id_is_br(id_is_br), .id_br_taken(id_br_taken), .id_sets_flags(id_sets_flags),
        .id_uses_flags(id_uses_flags), .id_is_halt(id_is_halt), .mem_stall(mem_stall),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .stall(stall), .hlt(hlt), .state(state)
    );

    task automatic drive(input logic v, input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                         input logic rsu, input logic rtu, input logic wr, input logic ld, input logic br,
                         input logic tk, input logic sf, input logic uf, input logic hl);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_used = rsu; id_rt_used = rtu;
        id_wr = wr; id_is_load = ld; id_is_br = br; id_br_taken = tk;
        id_sets_flags = sf; id_uses_flags = uf; id_is_halt = hl;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_stall = 1'b0; nop();
        #2;
        checks++;
        if (outs !== OK) begin errors++; $display("FAIL reset_outs got %b want %b", outs, OK); end
        checks++;
        if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        #1 rst = 1'b1;
        step();
    endtask

    task automatic test_load_use();
        drive(1, 1, 0, 3, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk); checks++;
        if (outs !== OK) begin errors++; $display("FAIL lw_issue got %b want %b", outs, OK); end
        step();
        drive(1, 3, 1, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); checks++;
        if (outs !== STL) begin errors++; $display("FAIL loaduse_stall got %b want %b", outs, STL); end
        step();
        @(negedge clk); checks++;
        if (outs !== OK) begin errors++; $display("FAIL loaduse_issue got %b want %b", outs, OK); end
        step();
        nop(); repeat (3) step();
    endtask

    task automatic test_alu_branch();
        drive(1, 1, 2, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); step();
        drive(1, 5, 2, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); checks++;
        if (outs !== OK) begin errors++; $display("FAIL alu_fwd got %b want %b", outs, OK); end
        step();
        drive(1, 1, 2, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); step();
        drive(1, 5, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk); checks++;
        if (outs !== STL) begin errors++; $display("FAIL br_alu_stall got %b want %b", outs, STL); end
        step();
        @(negedge clk); checks++;
        if (outs !== OK) begin errors++; $display("FAIL br_alu_go got %b want %b", outs, OK); end
        step();
        drive(1, 1, 0, 5, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk); step();
        drive(1, 5, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); checks++;
            if (outs !== STL) begin errors++; $display("FAIL br_lw_stall%0d got %b want %b", i, outs, STL); end
            step();
        end
        @(negedge clk); checks++;
        if (outs !== OK) begin errors++; $display("FAIL br_lw_go got %b want %b", outs, OK); end
        step();
        nop(); repeat (3) step();
    endtask

    task automatic test_flags();
        drive(1, 1, 2, 7, 1, 1, 1, 0, 0, 0, 1, 0, 0);
        @(negedge clk); step();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        @(negedge clk); checks++;
        if (outs !== STL) begin errors++; $display("FAIL flag_stall got %b want %b", outs, STL); end
        step();
        @(negedge clk); checks++;
        if (outs !== BRF) begin errors++; $display("FAIL taken_flush got %b want %b", outs, BRF); end
        step();
        nop();
        @(negedge clk); checks++;
        if (outs !== OK) begin errors++; $display("FAIL flush_once got %b want %b", outs, OK); end
        step();
        nop(); repeat (3) step();
    endtask

    task automatic test_mem_stall();
        drive(1, 1, 0, 3, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk); step();
        drive(1, 3, 1, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); checks++;
            if ({outs[8:2], outs[0]} !== 8'b0)
                begin errors++; $display("FAIL memstall%0d got %b want 0000000x0", i, outs); end
            step();
        end
        mem_stall = 1'b0;
        @(negedge clk); checks++;
        if (outs !== STL) begin errors++; $display("FAIL memstall_resume got %b want %b", outs, STL); end
        step();
        @(negedge clk); checks++;
        if (outs !== OK) begin errors++; $display("FAIL memstall_issue got %b want %b", outs, OK); end
        step();
        nop(); repeat (3) step();
    endtask

    task automatic test_halt();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); checks++;
        if (state !== 2'd0) begin errors++; $display("FAIL halt_issue_state got %0d want 0", state); end
        step();
        nop();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); checks++;
            if (outs !== (i == 2 ? DRH : DRN) || state !== 2'd1)
                begin errors++; $display("FAIL drain%0d got %b/%0d want %b/1", i, outs, state, i == 2 ? DRH : DRN); end
            step();
        end
        drive(1, 1, 2, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); checks++;
            if (outs !== HLD || state !== 2'd2)
                begin errors++; $display("FAIL halted%0d got %b/%0d want %b/2", i, outs, state, HLD); end
            step();
        end
        rst = 1'b0;
        #1; checks++;
        if (hlt !== 1'b0 || state !== 2'd0)
            begin errors++; $display("FAIL halted_reset got hlt=%b state=%0d want 0/0", hlt, state); end
        #1 rst = 1'b1;
        nop(); step();
    endtask

    task automatic test_reset_drain();
        drive(1, 1, 0, 3, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk); step();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); step();
        nop();
        @(negedge clk); checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL drain_entry got %0d want 1", state); end
        rst = 1'b0;
        #1; checks++;
        if (state !== 2'd0 || hlt !== 1'b0)
            begin errors++; $display("FAIL drain_reset got state=%0d hlt=%b want 0/0", state, hlt); end
        #1 rst = 1'b1;
        drive(1, 3, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        #1; checks++;
        if (outs !== OK) begin errors++; $display("FAIL counts_cleared got %b want %b", outs, OK); end
        step();
        drive(1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk); step();
        drive(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk); checks++;
        if (outs !== OK) begin errors++; $display("FAIL r0_branch got %b want %b", outs, OK); end
        step();
        drive(1, 0, 0, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); checks++;
        if (outs !== OK) begin errors++; $display("FAIL r0_alu got %b want %b", outs, OK); end
        step();
        nop(); repeat (3) step();
    endtask

    // Model: each producer stamps the tick at which EX and ID readers may consume its result.
    task automatic test_random();
        int ex_rdy[16];
        int id_rdy[16];
        int f_rdy;
        int t;
        logic v, rsu, rtu, wr, ld, br, tk, sf, uf, ms, haz, iss;
        logic [3:0] rs, rt, rd;
        logic [8:0] exp, mask;
        rst = 1'b0; #1 rst = 1'b1;
        nop(); step();
        for (int r = 0; r < 16; r++) begin ex_rdy[r] = 0; id_rdy[r] = 0; end
        f_rdy = 0; t = 0;
        for (int n = 0; n < 600; n++) begin
            v = $urandom_range(0, 3) != 0;
            rs = 4'($urandom_range(0, 3)); rt = 4'($urandom_range(0, 3)); rd = 4'($urandom_range(0, 3));
            rsu = 1'($urandom); rtu = 1'($urandom); wr = 1'($urandom); ld = 1'($urandom);
            br = $urandom_range(0, 3) == 0; tk = 1'($urandom);
            sf = $urandom_range(0, 2) == 0; uf = $urandom_range(0, 2) == 0;
            ms = $urandom_range(0, 7) == 0;
            drive(v, rs, rt, rd, rsu, rtu, wr, ld, br, tk, sf, uf, 0);
            mem_stall = ms;
            haz = v && ((rsu && rs != 0 && t < (br ? id_rdy[rs] : ex_rdy[rs])) ||
                        (rtu && rt != 0 && t < (br ? id_rdy[rt] : ex_rdy[rt])) ||
                        (uf && t < f_rdy));
            iss = v && !haz && !ms;
            exp = ms ? 9'b0 : haz ? STL : (iss && tk) ? BRF : OK;
            mask = ms ? 9'b111111101 : 9'h1FF;
            @(negedge clk); checks++;
            if ((outs & mask) !== exp)
                begin errors++; $display("FAIL random%0d got %b want %b", n, outs, exp); end
            if (iss && wr && rd != 0) begin
                ex_rdy[rd] = t + (ld ? 1 : 0) + 1;
                id_rdy[rd] = t + (ld ? 1 : 0) + 2;
            end
            if (iss && sf) f_rdy = t + 2;
            if (!ms) t++;
            step();
        end
        mem_stall = 1'b0; nop();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_alu_branch();
        test_flags();
        test_mem_stall();
        test_halt();
        test_reset_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

- Parametrised pipeline hazard and control unit for the WISC in-order pipeline.
- Owns every stall, flush and enable for the pipeline registers, plus halt drain and an optional external memory stall.
- Replaces ad-hoc enables with a per-register scoreboard (load-use, branch-register and flag hazards) and a RUN/DRAIN/HALTED state machine.
- Sits beside the datapath; consumes ID-stage decode, drives the PC and pipe-register enable/flush pins.

## Interface
Parameters:
- DEPTH, 5: pipeline stages IF..WB; minimum 4.
- NREG, 16: architectural registers; R0 is never tracked.
- RAW, 4: register index width, $clog2(NREG).
- LD_DLY, 1: load-result delay to an EX consumer under full forwarding.
- ALU_DLY, 0: ALU-result delay to an EX consumer.
- BR_EXTRA, 1: extra delay for consumers that read in ID (BR register, B flags).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  in  RAW  source/destination indices.
- id_rs_used, id_rt_used, id_wr  in  1  source reads / register write.
- id_is_load, id_is_br, id_br_taken  in  1  load; reads in ID (BR/B); ID branch resolved taken.
- id_sets_flags, id_uses_flags, id_is_halt  in  1  flag producer, flag consumer, HLT.
- mem_stall  in  1  external memory not ready.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register enables.
- if_id_flush, id_ex_flush  out  1  synchronous clears (bubble).
- stall  out  1  hazard stall this cycle.
- hlt  out  1  halt has reached WB.
- state  out  2  RUN=0, DRAIN=1, HALTED=2.

## Operation
- Scoreboard: per register r≠0, count cnt[r], width $clog2(LD_DLY+BR_EXTRA+1) (min 1), plus one flag count fcnt.
- Each non-mem_stall cycle, every nonzero count decrements by 1, saturating at 0.
- Issue = id_valid & ~stall & ~mem_stall & state==RUN.
- On issue with id_wr and id_rd≠0: cnt[rd] ← (id_is_load ? LD_DLY : ALU_DLY) + BR_EXTRA. This load overrides that register's decrement.
- On issue with id_sets_flags: fcnt ← ALU_DLY + BR_EXTRA.
- Hazard (source used, index≠0):
  - non-branch consumer stalls if cnt[src] > BR_EXTRA;
  - id_is_br consumer stalls if cnt[src] ≠ 0;
  - id_uses_flags stalls if fcnt ≠ 0.
- Stall response: pc_en=0, if_id_en=0, id_ex_flush=1; later stages advance.
- Taken branch: issue & id_br_taken drives if_id_flush=1 for one cycle. Ignored while stalled.
- Halt: issue & id_is_halt moves RUN→DRAIN with drain ← DEPTH-3. pc_en=0, if_id_flush=1 thereafter.
- DRAIN: drain decrements per non-mem_stall cycle. hlt=1 when drain==0; next edge → HALTED.
- HALTED: hlt=1; all enables 0; flushes 0; exit only via reset.
- Priority: mem_stall (all enables 0, counts/state hold, flushes 0) > HALTED > hazard stall > branch flush.

## Timing
- Single clock domain; all outputs combinational from registered state plus ID inputs. Zero-cycle decision latency.
- Reset (rst=0): state RUN, all counts 0, drain 0, hlt=0, stall=0. With id_valid=0: all enables 1, flushes 0.
- Reset asserted mid-DRAIN or in HALTED returns the unit to RUN immediately; hlt drops asynchronously.
- A hazard stall lasts until the blocking count decays; one bubble is inserted per stall cycle.
- Issue and decrement of the same register in one cycle: the issue value wins.
- id_rd==0 or id_wr=0: no scoreboard update.

## Structure
- Shared package wisc_pipe_pkg holds:
  - state encoding: RUN, DRAIN, HALTED;
  - default delay constants;
  - count-width function.
- Sub-module hz_scoreboard (NREG counters, flag counter, hazard compare) is the natural split. The state machine and enable logic stay in the top.

## Test plan
- LW R3 issues, ADD R4,R3,R1 next in ID → stall=1 for 1 cycle, id_ex_flush=1, pc_en=0; ADD issues the next cycle.
- ADD R5 then SUB R6,R5,R2 → no stall. Then BR via R5 immediately after ADD R5 → 1 stall cycle. After LW R5 → 2 stall cycles.
- ADD (sets flags) then B in ID → 1 stall. B then resolves taken → if_id_flush=1 for exactly 1 cycle.
- DEPTH=5, HLT issues at edge t0 → pc_en=0 from t0; hlt=1 in the 3rd cycle after t0; state=HALTED and hlt held.
- LW R3 / ADD R3 dependence with mem_stall=1 for 4 cycles → counts frozen, all enables 0; stall resumes for 1 cycle after mem_stall drops.
- rst low during DRAIN → state=RUN, hlt=0, counts 0. Write to R0 then read R0 → never stalls.
